// File: rtl/pipeline_trace_buffer.sv
// Logic-analyzer style trace buffer: captures multi-channel samples into a circular RAM
// around a trigger, then returns them oldest-first through a request/ack read port.
module pipeline_trace_buffer #(
    parameter int DATA_W    = 32,
    parameter int CH        = 2,
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 16
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       Arm,
    input  logic                       Cap_Valid,
    input  logic [CH*DATA_W-1:0]       Cap_Data,
    input  logic                       Trig,
    input  logic                       Rd_Req,
    output logic                       Rd_Ack,
    output logic [CH*DATA_W-1:0]       Rd_Data,
    output logic                       Rd_Last,
    output logic [1:0]                 State,
    output logic [$clog2(DEPTH):0]     Fill,
    output logic [$clog2(DEPTH)-1:0]   Trig_Index,
    output logic [31:0]                Cycle_Count
);
    // state | meaning
    // IDLE  | waiting for Arm; capture, trigger and reads ignored
    // ARMED | capturing pre-trigger history, waiting for Trig
    // POST  | capturing POST_TRIG samples after the trigger sample
    // DONE  | capture frozen, buffer readable oldest-first

    localparam int AW = $clog2(DEPTH);
    localparam int W  = CH * DATA_W;
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PT_LOAD = AW'(POST_TRIG);
    localparam logic          PT_ZERO = (POST_TRIG == 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     rd_cnt;
    logic [AW-1:0]   post_cnt;
    logic            trig_pending;
    logic [AW-1:0]   trig_addr;

    logic            capturing;
    logic            wr_en;
    logic [AW-1:0]   wr_ptr_nx;
    logic [AW:0]     fill_nx;
    logic [AW-1:0]   start_nx;
    logic [AW-1:0]   rd_start;
    logic [AW-1:0]   rd_addr;
    logic            trig_sample;
    logic            done_nx;
    logic [AW-1:0]   trig_addr_now;

    assign State = state;

    always_comb begin
        capturing     = (state == S_ARMED) || (state == S_POST);
        wr_en         = capturing && Cap_Valid && !Arm;
        wr_ptr_nx     = wr_ptr + 1'b1;
        fill_nx       = (Fill == FULL) ? Fill : Fill + 1'b1;
        start_nx      = (fill_nx == FULL) ? wr_ptr_nx : '0;
        rd_start      = (Fill == FULL) ? wr_ptr : '0;
        rd_addr       = rd_start + rd_cnt[AW-1:0];
        // The trigger sample is either the one coincident with Trig or the first one after it
        trig_sample   = wr_en && (((state == S_ARMED) && Trig) ||
                                  ((state == S_POST) && trig_pending));
        trig_addr_now = trig_sample ? wr_ptr : trig_addr;
        done_nx       = trig_sample ? PT_ZERO
                                    : ((state == S_POST) && wr_en && (post_cnt == AW'(1)));
    end

    // Buffer RAM carries no reset so it can map onto block memory
    always_ff @(posedge Clk) begin
        if (wr_en)
            mem[wr_ptr] <= Cap_Data;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_cnt       <= '0;
            post_cnt     <= '0;
            trig_pending <= 1'b0;
            trig_addr    <= '0;
            Fill         <= '0;
            Trig_Index   <= '0;
            Cycle_Count  <= '0;
            Rd_Ack       <= 1'b0;
            Rd_Last      <= 1'b0;
            Rd_Data      <= '0;
        end else begin
            Rd_Ack  <= 1'b0;
            Rd_Last <= 1'b0;
            if (Arm) begin
                state        <= S_ARMED;
                wr_ptr       <= '0;
                rd_cnt       <= '0;
                post_cnt     <= '0;
                trig_pending <= 1'b0;
                Fill         <= '0;
                Trig_Index   <= '0;
                Cycle_Count  <= '0;
            end else begin
                if (capturing && (Cycle_Count != '1))
                    Cycle_Count <= Cycle_Count + 1'b1;
                if (wr_en) begin
                    wr_ptr <= wr_ptr_nx;
                    Fill   <= fill_nx;
                end
                if (trig_sample)
                    trig_addr <= wr_ptr;
                if (done_nx)
                    Trig_Index <= trig_addr_now - start_nx;

                case (state)
                    S_ARMED: begin
                        if (Trig) begin
                            post_cnt     <= PT_LOAD;
                            trig_pending <= !Cap_Valid;
                            state        <= done_nx ? S_DONE : S_POST;
                        end
                    end
                    S_POST: begin
                        if (wr_en) begin
                            if (trig_pending)
                                trig_pending <= 1'b0;
                            else
                                post_cnt <= post_cnt - 1'b1;
                        end
                        if (done_nx)
                            state <= S_DONE;
                    end
                    S_DONE: begin
                        if (Rd_Req && (rd_cnt < Fill)) begin
                            Rd_Ack  <= 1'b1;
                            Rd_Data <= mem[rd_addr];
                            Rd_Last <= ((rd_cnt + 1'b1) == Fill);
                            rd_cnt  <= rd_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed bench for pipeline_trace_buffer with DATA_W=8, CH=2, DEPTH=8, POST_TRIG=2.
module tb_pipeline_trace_buffer;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Arm = 1'b0;
    logic        Cap_Valid = 1'b0;
    logic [15:0] Cap_Data = '0;
    logic        Trig = 1'b0;
    logic        Rd_Req = 1'b0;
    logic        Rd_Ack;
    logic [15:0] Rd_Data;
    logic        Rd_Last;
    logic [1:0]  State;
    logic [3:0]  Fill;
    logic [2:0]  Trig_Index;
    logic [31:0] Cycle_Count;

    int checks = 0;
    int passed = 0;

    pipeline_trace_buffer #(.DATA_W(8), .CH(2), .DEPTH(8), .POST_TRIG(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Arm(Arm), .Cap_Valid(Cap_Valid),
        .Cap_Data(Cap_Data), .Trig(Trig), .Rd_Req(Rd_Req), .Rd_Ack(Rd_Ack),
        .Rd_Data(Rd_Data), .Rd_Last(Rd_Last), .State(State), .Fill(Fill),
        .Trig_Index(Trig_Index), .Cycle_Count(Cycle_Count)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_arm();
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic t);
        Cap_Valid = 1'b1;
        Cap_Data  = d;
        Trig      = t;
        tick();
        Cap_Valid = 1'b0;
        Trig      = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (State !== 2'd0) $display("FAIL reset_state: got %0d want 0", State); else passed++;
        checks++; if (Fill !== 4'd0) $display("FAIL reset_fill: got %0d want 0", Fill); else passed++;
        checks++; if (Cycle_Count !== 32'd0 || Rd_Ack !== 1'b0 || Trig_Index !== 3'd0 || Rd_Data !== 16'h0)
            $display("FAIL reset_outputs: cc=%0d ack=%b ti=%0d data=%h want all 0", Cycle_Count, Rd_Ack, Trig_Index, Rd_Data);
        else passed++;
        #10 Reset_n = 1'b1;
        Cap_Valid = 1'b1; Trig = 1'b1; Rd_Req = 1'b1; Cap_Data = 16'hABCD;
        tick(); tick();
        Cap_Valid = 1'b0; Trig = 1'b0; Rd_Req = 1'b0;
        checks++; if (State !== 2'd0 || Fill !== 4'd0 || Rd_Ack !== 1'b0 || Cycle_Count !== 32'd0)
            $display("FAIL idle_ignore: state=%0d fill=%0d ack=%b cc=%0d want 0/0/0/0", State, Fill, Rd_Ack, Cycle_Count);
        else passed++;
    endtask

    task automatic test_no_wrap();
        logic [15:0] exp_d [5];
        exp_d[0] = 16'h0100; exp_d[1] = 16'h0201; exp_d[2] = 16'h0302;
        exp_d[3] = 16'h0403; exp_d[4] = 16'h0503;
        do_arm();
        checks++; if (State !== 2'd1 || Cycle_Count !== 32'd0)
            $display("FAIL nowrap_arm: state=%0d cc=%0d want 1/0", State, Cycle_Count);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            send(exp_d[i], i == 2);
            if (i == 3) begin
                checks++; if (State !== 2'd2) $display("FAIL nowrap_post: got %0d want 2", State); else passed++;
            end
        end
        checks++; if (State !== 2'd3) $display("FAIL nowrap_done: got %0d want 3", State); else passed++;
        checks++; if (Fill !== 4'd5) $display("FAIL nowrap_fill: got %0d want 5", Fill); else passed++;
        checks++; if (Trig_Index !== 3'd2) $display("FAIL nowrap_trig_index: got %0d want 2", Trig_Index); else passed++;
        checks++; if (Cycle_Count !== 32'd5) $display("FAIL nowrap_cycles: got %0d want 5", Cycle_Count); else passed++;
        tick();
        checks++; if (Cycle_Count !== 32'd5) $display("FAIL nowrap_cycles_hold: got %0d want 5", Cycle_Count); else passed++;
        for (int i = 0; i < 5; i++) begin
            Rd_Req = 1'b1;
            tick();
            Rd_Req = 1'b0;
            checks++;
            if (Rd_Ack !== 1'b1 || Rd_Data !== exp_d[i] || Rd_Last !== (i == 4))
                $display("FAIL nowrap_read%0d: ack=%b data=%h last=%b want 1/%h/%b", i, Rd_Ack, Rd_Data, Rd_Last, exp_d[i], i == 4);
            else passed++;
            tick();
            checks++;
            if (Rd_Ack !== 1'b0 || Rd_Data !== exp_d[i])
                $display("FAIL nowrap_hold%0d: ack=%b data=%h want 0/%h", i, Rd_Ack, Rd_Data, exp_d[i]);
            else passed++;
        end
        Rd_Req = 1'b1;
        tick();
        Rd_Req = 1'b0;
        checks++; if (Rd_Ack !== 1'b0 || State !== 2'd3)
            $display("FAIL nowrap_extra_read: ack=%b state=%0d want 0/3", Rd_Ack, State);
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_arm();
        for (int k = 1; k <= 12; k++)
            send(16'(k), k == 10);
        checks++; if (State !== 2'd3) $display("FAIL wrap_done: got %0d want 3", State); else passed++;
        checks++; if (Fill !== 4'd8) $display("FAIL wrap_fill: got %0d want 8", Fill); else passed++;
        checks++; if (Trig_Index !== 3'd5) $display("FAIL wrap_trig_index: got %0d want 5", Trig_Index); else passed++;
        Rd_Req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (Rd_Ack !== 1'b1 || Rd_Data !== 16'(i + 5) || Rd_Last !== (i == 7))
                $display("FAIL wrap_read%0d: ack=%b data=%h last=%b want 1/%h/%b", i, Rd_Ack, Rd_Data, Rd_Last, 16'(i + 5), i == 7);
            else passed++;
        end
        tick();
        Rd_Req = 1'b0;
        checks++; if (Rd_Ack !== 1'b0 || Rd_Last !== 1'b0)
            $display("FAIL wrap_past_end: ack=%b last=%b want 0/0", Rd_Ack, Rd_Last);
        else passed++;
    endtask

    task automatic test_trig_no_valid();
        logic [15:0] exp_d [3];
        exp_d[0] = 16'd1; exp_d[1] = 16'd2; exp_d[2] = 16'd7;
        do_arm();
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        Trig = 1'b1;
        tick();
        Trig = 1'b0;
        checks++; if (State !== 2'd2) $display("FAIL lone_trig_post: got %0d want 2", State); else passed++;
        send(16'd7, 1'b0);
        send(16'd8, 1'b0);
        checks++; if (State !== 2'd2) $display("FAIL lone_trig_still_post: got %0d want 2", State); else passed++;
        send(16'd9, 1'b0);
        checks++; if (State !== 2'd3 || Fill !== 4'd5 || Trig_Index !== 3'd2)
            $display("FAIL lone_trig_done: state=%0d fill=%0d ti=%0d want 3/5/2", State, Fill, Trig_Index);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            Rd_Req = 1'b1;
            tick();
            checks++;
            if (Rd_Ack !== 1'b1 || Rd_Data !== exp_d[i])
                $display("FAIL lone_trig_read%0d: ack=%b data=%h want 1/%h", i, Rd_Ack, Rd_Data, exp_d[i]);
            else passed++;
        end
        Rd_Req = 1'b0;
    endtask

    task automatic test_arm_priority();
        do_arm();
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        Arm = 1'b1; Trig = 1'b1; Cap_Valid = 1'b1; Cap_Data = 16'h00EE;
        tick();
        Arm = 1'b0; Trig = 1'b0; Cap_Valid = 1'b0;
        checks++; if (State !== 2'd1 || Fill !== 4'd0 || Cycle_Count !== 32'd0)
            $display("FAIL arm_over_trig: state=%0d fill=%0d cc=%0d want 1/0/0", State, Fill, Cycle_Count);
        else passed++;
        send(16'd3, 1'b0);
        checks++; if (State !== 2'd1 || Fill !== 4'd1)
            $display("FAIL arm_trig_ignored: state=%0d fill=%0d want 1/1", State, Fill);
        else passed++;
        send(16'd4, 1'b1);
        send(16'd5, 1'b0);
        send(16'd6, 1'b0);
        checks++; if (State !== 2'd3) $display("FAIL arm_prio_done: got %0d want 3", State); else passed++;
        Arm = 1'b1; Rd_Req = 1'b1;
        tick();
        Arm = 1'b0; Rd_Req = 1'b0;
        checks++; if (Rd_Ack !== 1'b0 || State !== 2'd1)
            $display("FAIL arm_over_read: ack=%b state=%0d want 0/1", Rd_Ack, State);
        else passed++;
    endtask

    task automatic test_async_reset();
        send(16'd1, 1'b1);
        checks++; if (State !== 2'd2 || Cycle_Count == 32'd0)
            $display("FAIL areset_setup: state=%0d cc=%0d want 2/nonzero", State, Cycle_Count);
        else passed++;
        #2 Reset_n = 1'b0;
        #1;
        checks++; if (State !== 2'd0 || Fill !== 4'd0 || Cycle_Count !== 32'd0)
            $display("FAIL areset_immediate: state=%0d fill=%0d cc=%0d want 0/0/0", State, Fill, Cycle_Count);
        else passed++;
        #1 Reset_n = 1'b1;
        send(16'd2, 1'b1);
        tick();
        checks++; if (State !== 2'd0 || Fill !== 4'd0)
            $display("FAIL areset_trig_ignored: state=%0d fill=%0d want 0/0", State, Fill);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_no_wrap();
        test_back_to_back();
        test_trig_no_valid();
        test_arm_priority();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
